// File: rtl/serial_pkg.sv
// Shared types and constants for the serial IP.
// Used by the transmitter and, later, the receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  localparam logic [1:0] SIZE_5 = 2'b00;
  localparam logic [1:0] SIZE_6 = 2'b01;
  localparam logic [1:0] SIZE_7 = 2'b10;
  localparam logic [1:0] SIZE_8 = 2'b11;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_STICK = 2'b11;

  // Smallest divisor that still gives two clocks per bit.
  localparam logic [31:0] BRD_MIN = 32'h200;

  function automatic logic [7:0] size_mask(
    input logic [1:0] sz
  );
    logic [7:0] m;
    unique case (sz)
      SIZE_5:  m = 8'h1F;
      SIZE_6:  m = 8'h3F;
      SIZE_7:  m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic parity_bit(
    input logic [1:0] mode,
    input logic [8:0] word,
    input logic [1:0] sz
  );
    logic x;
    logic p;
    x = ^(word[7:0] & size_mask(sz));
    unique case (mode)
      PAR_EVEN:  p = x;
      PAR_ODD:   p = ~x;
      PAR_STICK: p = word[8];
      default:   p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// FIFO read port between the TX FIFO and the serializer.
// First-word-fall-through: data is valid while not empty.
interface serial_tx_if;
  logic       fifo_empty;
  logic [8:0] fifo_rd_data;
  logic       fifo_rd_request;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_request
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_request
  );
endinterface

// File: rtl/serial_baud_gen.sv
// Fractional bit-period accumulator (24.8 divisor).
// Adds one clock (256) per cycle and ticks on wrap.
module serial_baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] brd_l,
  output logic        tick
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [32:0] sum;

  // Next accumulator value and tick from acc+256 vs divisor.
  always_comb begin
    sum  = {1'b0, acc_q} + 33'd256;
    tick = (sum >= {1'b0, brd_l});
    acc_d = sum[31:0];
    if (tick) begin
      acc_d = 32'(sum - {1'b0, brd_l});
    end
    if (clear) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: pops FIFO words and shifts out
// start, 5-8 data bits, optional parity, 1-2 stops.
module serial_tx
  import serial_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [31:0]  brd,
  input  logic [1:0]   size,
  input  logic [1:0]   parity,
  input  logic         stop2,
  input  logic         send_break,
  serial_tx_if.master  fifo,
  output logic         tx,
  output logic         busy
);

  tx_state_t   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [8:0]  data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  par_q, par_d;
  logic        stop2_q, stop2_d;
  logic [31:0] brd_q, brd_d;
  logic        tx_q, tx_d;

  logic        tick;
  logic        launch_ok;
  logic        pop;
  logic        frame_end;
  logic        clear;
  logic [2:0]  last_bit;

  assign launch_ok = enable && (brd >= BRD_MIN) &&
                     !fifo.fifo_empty && !send_break &&
                     !reset;
  assign last_bit  = {1'b0, size_q} + 3'd4;
  assign clear     = pop || (state_q == ST_IDLE);

  serial_baud_gen u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .brd_l (brd_q),
    .tick  (tick)
  );

  // Frame sequencing, pop/latch, and next line level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    size_d    = size_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    brd_d     = brd_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch_ok) pop = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt_q == last_bit) begin
            state_d = (par_q != PAR_NONE) ?
                      ST_PARITY : ST_STOP1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (tick) begin
          if (stop2_q) state_d = ST_STOP2;
          else         frame_end = 1'b1;
        end
      end
      ST_STOP2: begin
        if (tick) frame_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      state_d = ST_IDLE;
      if (launch_ok) pop = 1'b1;
    end

    if (pop) begin
      state_d = ST_START;
      data_d  = fifo.fifo_rd_data;
      size_d  = size;
      par_d   = parity;
      stop2_d = stop2;
      brd_d   = brd;
    end

    unique case (state_d)
      ST_IDLE:   tx_d = ~send_break;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[cnt_d];
      ST_PARITY: tx_d = parity_bit(par_q, data_q, size_q);
      default:   tx_d = 1'b1;
    endcase
  end

  // State and latched frame configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      size_q  <= '0;
      par_q   <= '0;
      stop2_q <= 1'b0;
      brd_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      size_q  <= size_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      brd_q   <= brd_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo.fifo_rd_request = pop;
  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with a small FWFT FIFO model.
// Expected line levels are built from hand-computed frames.
module tb_serial_tx;
  import serial_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] brd = 32'h400;
  logic [1:0]  size = 2'b11;
  logic [1:0]  parity = 2'b00;
  logic        stop2 = 1'b0;
  logic        send_break = 1'b0;
  logic        tx;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [8:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int pop_n = 0;
  int pop_cyc [64];
  int n0;

  serial_tx_if fif ();

  assign fif.fifo_empty   = (wr_ptr == rd_ptr);
  assign fif.fifo_rd_data = mem[rd_ptr % 16];

  serial_tx dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .brd        (brd),
    .size       (size),
    .parity     (parity),
    .stop2      (stop2),
    .send_break (send_break),
    .fifo       (fif),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.fifo_rd_request) begin
      rd_ptr <= rd_ptr + 1;
      pop_cyc[pop_n % 64] <= cyc;
      pop_n <= pop_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    #1;
    while (!fif.fifo_rd_request && n < 200) begin
      step();
      n++;
    end
    chk1(tag, fif.fifo_rd_request, 1'b1);
  endtask

  task automatic check_bits(input string tag,
                            input logic [15:0] lv,
                            input int nb,
                            input int per);
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < per; c++) begin
        step();
        chk1($sformatf("%s_b%0d_c%0d", tag, i, c),
             tx, lv[i]);
        if (c == 0)
          chk1($sformatf("%s_busy%0d", tag, i),
               busy, 1'b1);
      end
    end
  endtask

  task automatic check_frac(input string tag,
                            input logic [15:0] lv,
                            input int nb);
    int per;
    for (int i = 0; i < nb; i++) begin
      per = (i % 2 == 0) ? 3 : 2;
      for (int c = 0; c < per; c++) begin
        step();
        chk1($sformatf("%s_b%0d_c%0d", tag, i, c),
             tx, lv[i]);
      end
    end
  endtask

  initial begin
    enable = 1'b1;
    push(9'h055);
    step();
    step();
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req", fif.fifo_rd_request, 1'b0);
    chkn("rst_pops", pop_n, 0);
    reset = 1'b0;

    wait_pop("8n1_pop");
    check_bits("8n1", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 4);
    step();
    chk1("8n1_busy_end", busy, 1'b0);
    chk1("8n1_tx_end", tx, 1'b1);
    chkn("8n1_pops", pop_n, 1);

    size = 2'b10;
    parity = PAR_EVEN;
    stop2 = 1'b1;
    push(9'h007);
    wait_pop("even_pop");
    check_bits("even",
      {5'b0, 1'b1, 1'b1, 1'b1, 7'h07, 1'b0}, 11, 4);
    step();
    chk1("even_idle", busy, 1'b0);

    parity = PAR_ODD;
    push(9'h007);
    wait_pop("odd_pop");
    check_bits("odd",
      {5'b0, 1'b1, 1'b1, 1'b0, 7'h07, 1'b0}, 11, 4);
    step();
    chk1("odd_idle", busy, 1'b0);

    parity = PAR_STICK;
    push(9'h100);
    wait_pop("stick_pop");
    check_bits("stick",
      {5'b0, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0}, 11, 4);
    step();
    chk1("stick_idle", busy, 1'b0);

    size = 2'b11;
    parity = PAR_NONE;
    stop2 = 1'b0;
    n0 = pop_n;
    push(9'h0A5);
    push(9'h13C);
    push(9'h0FF);
    wait_pop("b2b_pop");
    check_bits("b2b0", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4);
    check_bits("b2b1", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    check_bits("b2b2", {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4);
    step();
    chk1("b2b_idle", busy, 1'b0);
    chkn("b2b_pops", pop_n - n0, 3);
    chkn("b2b_gap01",
         pop_cyc[(n0 + 1) % 64] - pop_cyc[n0 % 64], 40);
    chkn("b2b_gap12",
         pop_cyc[(n0 + 2) % 64] - pop_cyc[(n0 + 1) % 64], 40);

    brd = 32'h280;
    push(9'h0C3);
    wait_pop("frac_pop");
    check_frac("frac", {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    step();
    chk1("frac_idle", busy, 1'b0);

    brd = 32'h400;
    send_break = 1'b1;
    step();
    chk1("brk_tx", tx, 1'b0);
    push(9'h081);
    n0 = pop_n;
    repeat (5) step();
    chk1("brk_tx_hold", tx, 1'b0);
    chk1("brk_busy", busy, 1'b0);
    chkn("brk_nopop", pop_n, n0);
    send_break = 1'b0;
    #1;
    chk1("brk_release_pop", fif.fifo_rd_request, 1'b1);
    check_bits("brk_frame", {6'b0, 1'b1, 8'h81, 1'b0}, 10, 4);
    step();
    chk1("brk_idle", busy, 1'b0);

    brd = 32'h1FF;
    push(9'h033);
    n0 = pop_n;
    repeat (20) step();
    chkn("badbrd_nopop", pop_n, n0);
    chk1("badbrd_tx", tx, 1'b1);
    chk1("badbrd_busy", busy, 1'b0);

    brd = 32'h400;
    wait_pop("abort_pop");
    repeat (10) step();
    chk1("abort_busy_pre", busy, 1'b1);
    push(9'h05A);
    reset = 1'b1;
    #1;
    chk1("abort_tx", tx, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    n0 = pop_n;
    step();
    chk1("abort_req_rst", fif.fifo_rd_request, 1'b0);
    reset = 1'b0;
    wait_pop("fresh_pop");
    check_bits("fresh", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 4);
    step();
    chkn("fresh_pops", pop_n, n0 + 1);
    chk1("fresh_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
